conv_stream_param: RTL and testbench

- Parametrised successor to the fixed 8x4 streaming convolver.
- Accepts a signed input vector x (length N) and a signed filter f (length M) on two independent valid/ready streams, each stored in a local buffer.
- Computes all N-M+1 valid-mode outputs y[j] = sum_{k=0..M-1} x[j+k]*f[k].
- Emits the outputs in order on a valid/ready master stream, then returns to load the next frame.

---
 rtl/conv_stream_param.sv | 173 +++++++++++++++++
 tb/tb_conv_stream_param.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_stream_param.sv
`default_nettype none
// ============================================================================
//  Module   : conv_stream_param
//  Purpose  : Streaming valid-mode 1-D convolver. Loads an N-sample signed x
//             vector and an M-tap signed filter over two independent
//             valid/ready streams. It then emits y[j] = sum_k x[j+k]*f[k] for
//             j = 0..N-M on a valid/ready master stream.
//  Options  : CONV_RELU_EN - clamp negative results to zero in the output
//             register (no added latency).
//  Revision : 1.0 - initial parametrised release
// ============================================================================
module conv_stream_param #(
  parameter int WX = 8,
  parameter int WF = 8,
  parameter int N  = 8,
  parameter int M  = 4
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic signed [WX-1:0]                 s_data_in_x,
  input  logic                                 s_valid_x,
  output logic                                 s_ready_x,
  input  logic signed [WF-1:0]                 s_data_in_f,
  input  logic                                 s_valid_f,
  output logic                                 s_ready_f,
  output logic signed [WX+WF+$clog2(M)-1:0]    m_data_out_y,
  output logic                                 m_valid_y,
  input  logic                                 m_ready_y
);

  localparam int WY  = WX + WF + $clog2(M);
  localparam int WP  = WX + WF;
  localparam int XCW = $clog2(N + 1);
  localparam int FCW = $clog2(M + 1);
  localparam int XAW = $clog2(N);
  localparam int FAW = $clog2(M);

  localparam logic [XCW-1:0] X_FULL = XCW'(N);
  localparam logic [FCW-1:0] F_FULL = FCW'(M);
  localparam logic [XAW-1:0] J_LAST = XAW'(N - M);

  typedef enum logic [1:0] {
    LOAD    = 2'd0,
    COMPUTE = 2'd1,
    OUTPUT  = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic signed [WX-1:0] x_buf [N];
  logic signed [WF-1:0] f_buf [M];

  logic [XCW-1:0]       x_cnt, x_cnt_nxt;
  logic [FCW-1:0]       f_cnt, f_cnt_nxt;
  logic [XAW-1:0]       j_idx;
  logic [FCW-1:0]       k_cnt;
  logic [XAW-1:0]       x_addr;
  logic [FAW-1:0]       f_addr;
  logic signed [WX-1:0] x_rd;
  logic signed [WF-1:0] f_rd;
  logic signed [WP-1:0] prod;
  logic signed [WY-1:0] prod_ext;
  logic signed [WY-1:0] acc;
  logic signed [WY-1:0] y_val;
  logic                 x_fire, f_fire, y_fire, frame_done;

  assign x_fire     = s_valid_x & s_ready_x;
  assign f_fire     = s_valid_f & s_ready_f;
  assign y_fire     = m_valid_y & m_ready_y;
  assign frame_done = (state == OUTPUT) && y_fire && (j_idx == J_LAST);

  // Tap k of window j reads x[j+k] and f[k]; k_cnt never exceeds M-1 when used
  assign x_addr   = j_idx + XAW'(k_cnt);
  assign f_addr   = FAW'(k_cnt);
  assign prod     = x_rd * f_rd;
  assign prod_ext = {{(WY - WP){prod[WP-1]}}, prod};

`ifdef CONV_RELU_EN
  assign y_val = acc[WY-1] ? '0 : acc;
`else
  assign y_val = acc;
`endif

  // Write-counter next values: cleared when the last result of a frame leaves
  always_comb begin
    x_cnt_nxt = x_cnt;
    f_cnt_nxt = f_cnt;
    if (frame_done) begin
      x_cnt_nxt = '0;
      f_cnt_nxt = '0;
    end else begin
      if (x_fire) x_cnt_nxt = x_cnt + XCW'(1);
      if (f_fire) f_cnt_nxt = f_cnt + FCW'(1);
    end
  end

  // Next-state logic for the LOAD / COMPUTE / OUTPUT sequencer
  always_comb begin
    state_nxt = state;
    case (state)
      LOAD:    if (x_cnt == X_FULL && f_cnt == F_FULL) state_nxt = COMPUTE;
      COMPUTE: if (k_cnt == F_FULL) state_nxt = OUTPUT;
      OUTPUT:  if (y_fire) state_nxt = (j_idx == J_LAST) ? LOAD : COMPUTE;
      default: state_nxt = LOAD;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= LOAD;
    else        state <= state_nxt;
  end

  // Load-side counters and registered readies (high only while loading and not full)
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      x_cnt     <= '0;
      f_cnt     <= '0;
      s_ready_x <= 1'b0;
      s_ready_f <= 1'b0;
    end else begin
      x_cnt     <= x_cnt_nxt;
      f_cnt     <= f_cnt_nxt;
      s_ready_x <= (state_nxt == LOAD) && (x_cnt_nxt != X_FULL);
      s_ready_f <= (state_nxt == LOAD) && (f_cnt_nxt != F_FULL);
    end
  end

  // Sample buffers; contents need no reset because counters gate their use
  always_ff @(posedge clk) begin
    if (x_fire) x_buf[x_cnt[XAW-1:0]] <= s_data_in_x;
    if (f_fire) f_buf[f_cnt[FAW-1:0]] <= s_data_in_f;
  end

  // MAC pipeline: read tap k on cycle k, accumulate its product on cycle k+1
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      k_cnt <= '0;
      x_rd  <= '0;
      f_rd  <= '0;
      acc   <= '0;
    end else if (state != COMPUTE && state_nxt == COMPUTE) begin
      k_cnt <= '0;
      acc   <= '0;
    end else if (state == COMPUTE) begin
      if (k_cnt != F_FULL) begin
        k_cnt <= k_cnt + FCW'(1);
        x_rd  <= x_buf[x_addr];
        f_rd  <= f_buf[f_addr];
      end
      if (k_cnt != '0) acc <= acc + prod_ext;
    end
  end

  // Output register: capture the finished sum once, hold it until accepted
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_valid_y    <= 1'b0;
      m_data_out_y <= '0;
      j_idx        <= '0;
    end else if (state == OUTPUT) begin
      if (!m_valid_y) begin
        m_data_out_y <= y_val;
        m_valid_y    <= 1'b1;
      end else if (m_ready_y) begin
        m_valid_y <= 1'b0;
        j_idx     <= (j_idx == J_LAST) ? '0 : j_idx + XAW'(1);
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_conv_stream_param.sv
`default_nettype none
// ============================================================================
//  Module   : tb_conv_stream_param
//  Purpose  : Self-checking bench for conv_stream_param (8x4 default instance
//             and a 16x5, 12x6-bit instance) against a behavioural model.
//  Options  : CONV_RELU_EN - model clamps negative results to zero.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_conv_stream_param;

  logic   clk   = 1'b0;
  logic   reset = 1'b1;
  longint cyc   = 0;
  int     vectors     = 0;
  int     miscompares = 0;

  // Instance A: default parameters
  logic signed [7:0]  ax = '0, af = '0;
  logic               avx = 1'b0, avf = 1'b0, ary = 1'b0;
  logic               arx, arf, avy;
  logic signed [17:0] ay;

  // Instance B: N=16, M=5, WX=12, WF=6 (WY=21)
  logic signed [11:0] bx = '0;
  logic signed [5:0]  bf = '0;
  logic               bvx = 1'b0, bvf = 1'b0, bry = 1'b0;
  logic               brx, brf, bvy;
  logic signed [20:0] by;

  int xv [16];
  int fv [5];

  conv_stream_param u_dut_a (
    .clk(clk), .reset(reset),
    .s_data_in_x(ax), .s_valid_x(avx), .s_ready_x(arx),
    .s_data_in_f(af), .s_valid_f(avf), .s_ready_f(arf),
    .m_data_out_y(ay), .m_valid_y(avy), .m_ready_y(ary)
  );

  conv_stream_param #(.WX(12), .WF(6), .N(16), .M(5)) u_dut_b (
    .clk(clk), .reset(reset),
    .s_data_in_x(bx), .s_valid_x(bvx), .s_ready_x(brx),
    .s_data_in_f(bf), .s_valid_f(bvf), .s_ready_f(brf),
    .m_data_out_y(by), .m_valid_y(bvy), .m_ready_y(bry)
  );

  // Free-running clock and cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input longint got, input longint exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference: direct sum of products over the stored frame
  function automatic longint model_y(input int j, input int m);
    longint s = 0;
    for (int k = 0; k < m; k++) s += longint'(xv[j + k]) * longint'(fv[k]);
`ifdef CONV_RELU_EN
    if (s < 0) s = 0;
`endif
    return s;
  endfunction

  function automatic bit rd(input int sel);
    case (sel)
      0:       return arx;
      1:       return arf;
      2:       return brx;
      default: return brf;
    endcase
  endfunction

  function automatic bit yv(input int d);
    return (d == 0) ? avy : bvy;
  endfunction

  function automatic longint yd(input int d);
    return (d == 0) ? longint'(ay) : longint'(by);
  endfunction

  task automatic drive(input int sel, input int v, input bit vld);
    case (sel)
      0:       begin ax = v[7:0];  avx = vld; end
      1:       begin af = v[7:0];  avf = vld; end
      2:       begin bx = v[11:0]; bvx = vld; end
      default: begin bf = v[5:0];  bvf = vld; end
    endcase
  endtask

  task automatic set_ready(input int d, input bit r);
    if (d == 0) ary = r;
    else        bry = r;
  endtask

  // Push one word; called and returns at a falling edge
  task automatic push(input int sel, input int v, input bit gaps);
    int t;
    t = 0;
    if (gaps) repeat ($urandom_range(3)) @(negedge clk);
    drive(sel, v, 1'b1);
    while (!rd(sel) && t < 50) begin
      @(negedge clk);
      t++;
    end
    check("s_ready_wait", longint'(rd(sel)), 1);
    @(posedge clk);
    @(negedge clk);
    drive(sel, 0, 1'b0);
  endtask

  task automatic load(input int d, input int n, input int m, input bit f_first, input bit gaps);
    if (f_first) for (int k = 0; k < m; k++) push(2 * d + 1, fv[k], gaps);
    for (int i = 0; i < n; i++) push(2 * d, xv[i], gaps);
    if (!f_first) for (int k = 0; k < m; k++) push(2 * d + 1, fv[k], gaps);
  endtask

  task automatic fill(input int d);
    for (int i = 0; i < 16; i++)
      xv[i] = (d == 0) ? int'($urandom_range(255)) - 128 : int'($urandom_range(4095)) - 2048;
    for (int k = 0; k < 5; k++)
      fv[k] = (d == 0) ? int'($urandom_range(255)) - 128 : int'($urandom_range(63)) - 32;
  endtask

  // Receive nres results; ref_c is the cycle stamp of the last load word
  task automatic collect(input int d, input int n, input int m, input int pct,
                         input int stall_j, input int nres, input longint load_cyc);
    longint ref_c;
    int     t, hold;
    bit     r;
    ref_c = load_cyc;
    for (int j = 0; j < nres && j <= n - m; j++) begin
      t = 0; hold = 0; r = 1'b0;
      while (!yv(d) && t < 100) begin
        set_ready(d, 1'($urandom_range(1)));
        @(negedge clk);
        t++;
      end
      check("y_valid_wait", longint'(yv(d)), 1);
      if (!yv(d)) return;
      check("y_latency", cyc - ref_c, (j == 0) ? m + 3 : m + 2);
      while (!r) begin
        check("y_valid_hold", longint'(yv(d)), 1);
        check("y_data", yd(d), model_y(j, m));
        if (j == stall_j) begin
          check("s_ready_x_in_output", longint'(arx), 0);
          r = (hold >= 10);
          drive(0, 85, (hold % 2 == 0) && !r);
          hold++;
        end else begin
          r = (int'($urandom_range(99)) < pct);
        end
        set_ready(d, r);
        @(negedge clk);
      end
      if (j == stall_j) drive(0, 0, 1'b0);
      ref_c = cyc;
      check("y_valid_drop", longint'(yv(d)), 0);
    end
  endtask

  task automatic frame(input int d, input int n, input int m, input bit f_first,
                       input bit gaps, input int pct, input int stall_j);
    longint l;
    load(d, n, m, f_first, gaps);
    l = cyc;
    collect(d, n, m, pct, stall_j, n - m + 1, l);
    check("s_ready_x_reload", longint'(rd(2 * d)), 1);
    check("s_ready_f_reload", longint'(rd(2 * d + 1)), 1);
  endtask

  // Main stimulus sequence
  initial begin
    longint l;
    #1 reset = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_ready_x", longint'(arx), 0);
    check("rst_ready_f", longint'(arf), 0);
    check("rst_valid_y", longint'(avy), 0);
    check("rst_data_y", longint'(ay), 0);
    check("rst_valid_y_b", longint'(bvy), 0);
    reset = 1'b1;
    @(negedge clk);
    check("post_rst_ready_x", longint'(arx), 1);
    check("post_rst_ready_f", longint'(arf), 1);

    // Ramp x with unit filter
    for (int i = 0; i < 8; i++) xv[i] = i + 1;
    for (int k = 0; k < 4; k++) fv[k] = 1;
    frame(0, 8, 4, 1'b0, 1'b0, 100, -1);

    // Negative results, filter loaded first, gappy valids
    for (int i = 0; i < 8; i++) xv[i] = -1;
    for (int k = 0; k < 4; k++) fv[k] = 2;
    frame(0, 8, 4, 1'b1, 1'b1, 100, -1);

    // Extreme magnitudes
    for (int i = 0; i < 8; i++) xv[i] = -128;
    for (int k = 0; k < 4; k++) fv[k] = -128;
    frame(0, 8, 4, 1'b0, 1'b0, 100, -1);

    // Backpressure on y[2] with stray x valids during OUTPUT
    for (int i = 0; i < 8; i++) xv[i] = i + 1;
    for (int k = 0; k < 4; k++) fv[k] = 1;
    frame(0, 8, 4, 1'b0, 1'b0, 100, 2);

    // Reset in the middle of computing y[1]
    fill(0);
    load(0, 8, 4, 1'b0, 1'b0);
    l = cyc;
    collect(0, 8, 4, 100, -1, 1, l);
    @(negedge clk);
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    check("midrst_data_y", longint'(ay), 0);
    check("midrst_valid_y", longint'(avy), 0);
    check("midrst_ready_x", longint'(arx), 0);
    check("midrst_ready_f", longint'(arf), 0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("midrst_release_ready_x", longint'(arx), 1);
    check("midrst_release_ready_f", longint'(arf), 1);
    fill(0);
    frame(0, 8, 4, 1'b0, 1'b1, 60, -1);

    // Random frames on the default instance
    repeat (3) begin
      fill(0);
      frame(0, 8, 4, 1'($urandom_range(1)), 1'b1, 50, -1);
    end

    // Random frames on the wide instance
    repeat (3) begin
      fill(1);
      frame(1, 16, 5, 1'($urandom_range(1)), 1'b1, 70, -1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
